uart_packet_sender: RTL and testbench

- Serialises a parallel packet of PACKET_SIZE bytes onto a UART TX line, 8N1 framing, LSB-first bits.
- A one-cycle enable pulse captures the whole packet. Bytes go out back-to-back, most-significant byte first.
- Sits between packet-producing logic (e.g. FFT result buffer) and the FTDI UART pin.

---
 rtl/uart_packet_sender.sv | 133 +++++++++++++
 tb/tb_uart_packet_sender.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_sender.sv
// Sends a PACKET_SIZE-byte packet as back-to-back 8N1 UART frames, MSB byte first, bits LSB first.
// Optional macro PACKET_SENDER_CHECKSUM_EN appends a frame carrying the mod-256 byte sum.
module uart_packet_sender #(
  parameter logic [15:0] PACKET_SIZE  = 16'd9,
  parameter int          CLKS_PER_BIT = 104
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [8*int'(PACKET_SIZE)-1:0] packet,
  input  logic                           enable,
  output logic                           txd,
  output logic                           busy
);

  localparam int PW    = 8 * int'(PACKET_SIZE);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef PACKET_SENDER_CHECKSUM_EN
  localparam logic [15:0] LAST_IDX = PACKET_SIZE;
`else
  localparam logic [15:0] LAST_IDX = PACKET_SIZE - 16'd1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  logic             r_txd;
  logic             r_busy;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [15:0]      r_byte_idx;
  logic [PW-1:0]    r_buf;
`ifdef PACKET_SENDER_CHECKSUM_EN
  logic [7:0]       r_sum;
  logic [7:0]       w_sum_next;
`endif

  logic       w_bit_done;
  logic [7:0] w_cur_byte;

  // The frame being sent always sits in the top byte; the buffer shifts left per frame.
  assign w_cur_byte = r_buf[PW-1 -: 8];
  assign w_bit_done = (r_clk_cnt == CNT_LAST);
`ifdef PACKET_SENDER_CHECKSUM_EN
  assign w_sum_next = r_sum + w_cur_byte;
`endif

  assign txd  = r_txd;
  assign busy = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_buf      <= '0;
`ifdef PACKET_SENDER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_buf      <= packet;
            r_byte_idx <= '0;
            r_clk_cnt  <= '0;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
`ifdef PACKET_SENDER_CHECKSUM_EN
            r_sum      <= '0;
`endif
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_txd     <= w_cur_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= w_cur_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_byte_idx == LAST_IDX) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_txd      <= 1'b0;
              r_byte_idx <= r_byte_idx + 16'd1;
              r_buf      <= r_buf << 8;
              r_state    <= S_START;
`ifdef PACKET_SENDER_CHECKSUM_EN
              r_sum <= w_sum_next;
              // After the last data byte, the top slot is refilled with the running sum.
              if (r_byte_idx == PACKET_SIZE - 16'd1)
                r_buf[PW-1 -: 8] <= w_sum_next;
`endif
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_sender.sv
// Bench for uart_packet_sender: compares txd/busy each cycle against a bit-stream model
// and decodes the UART frames back into bytes.
module tb_uart_packet_sender;

  localparam int CPB = 4;
  localparam int PS  = 9;
  localparam int PW  = 8 * PS;
`ifdef PACKET_SENDER_CHECKSUM_EN
  localparam int NF = PS + 1;
`else
  localparam int NF = PS;
`endif
  localparam int FRAME = 10 * CPB;
  localparam int TOTAL = NF * FRAME;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] packet = '0;
  logic          txd;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] last_dec [NF];
  logic [PW-1:0] pkt_digits;
  logic [PW-1:0] pkt_letters;

  always #5 clk = ~clk;

  uart_packet_sender #(
    .PACKET_SIZE (16'd9),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .packet(packet),
    .enable(enable),
    .txd   (txd),
    .busy  (busy)
  );

  // Frame k of a packet: data byte k (MSB byte first), or the byte sum for the extra frame.
  function automatic logic [7:0] model_byte(input logic [PW-1:0] p, input int k);
    logic [7:0] s;
    if (k < PS) return p[PW-1-8*k -: 8];
    s = 8'd0;
    for (int i = 0; i < PS; i++) s = s + p[PW-1-8*i -: 8];
    return s;
  endfunction

  function automatic logic [PW-1:0] rand_packet();
    logic [PW-1:0] p;
    for (int i = 0; i < PS; i++) p[8*i +: 8] = 8'($urandom);
    return p;
  endfunction

  task automatic check_idle(input int cycles, input string name);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_vec++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle cycle %0d: txd=%b busy=%b, required txd=1 busy=0", name, c, txd, busy);
      end
    end
  endtask

  task automatic run_packet(input logic [PW-1:0] p, input bit pre_armed, input bit spam,
                            input bit scramble, input bit chain, input logic [PW-1:0] next_p,
                            input string name);
    logic       exp_bits[$];
    logic       got [TOTAL];
    logic [7:0] b;
    logic [7:0] dec;
    int         e0;
    e0 = n_err;
    exp_bits.delete();
    for (int f = 0; f < NF; f++) begin
      b = model_byte(p, f);
      for (int i = 0; i < 10; i++)
        for (int c = 0; c < CPB; c++)
          exp_bits.push_back((i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1]);
    end
    if (!pre_armed) begin
      @(negedge clk);
      packet = p;
      enable = 1'b1;
    end
    @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < TOTAL; c++) begin
      got[c] = txd;
      n_vec++;
      if (busy !== 1'b1 || txd !== exp_bits[c]) begin
        n_err++;
        $display("FAIL %s cycle %0d: txd=%b busy=%b, required txd=%b busy=1", name, c, txd, busy, exp_bits[c]);
      end
      if (scramble && c == 1) packet = ~p;
      enable = (spam && (c % 50) == 25) || (chain && c == TOTAL - 1);
      if (chain && c == TOTAL - 1) packet = next_p;
      @(negedge clk);
    end
    n_vec++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      n_err++;
      $display("FAIL %s end: txd=%b busy=%b, required txd=1 busy=0", name, txd, busy);
    end
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < 8; i++) dec[i] = got[f*FRAME + (i+1)*CPB + CPB/2];
      last_dec[f] = dec;
      n_vec++;
      if (dec !== model_byte(p, f)) begin
        n_err++;
        $display("FAIL %s decode frame %0d: got 0x%02h, required 0x%02h", name, f, dec, model_byte(p, f));
      end
    end
    $display("%s: packet 0x%h, %0d frames, %0d errors", name, p, NF, n_err - e0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: txd=%b busy=%b, required txd=1 busy=0", txd, busy);
    end
    rst = 1'b0;
    check_idle(5, "reset_release");
    @(negedge clk);
    packet = rand_packet();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_vec++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre: txd=%b busy=%b, required txd=0 busy=1", txd, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: txd=%b busy=%b, required txd=1 busy=0", txd, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle(3 * FRAME, "reset_after");
    $display("test_reset: done, %0d errors so far", n_err);
  endtask

  task automatic test_single();
    run_packet(pkt_digits, 1'b0, 1'b0, 1'b0, 1'b0, '0, "single");
    for (int k = 0; k < PS; k++) begin
      n_vec++;
      if (last_dec[k] !== 8'(8'h31 + k)) begin
        n_err++;
        $display("FAIL single_ascii byte %0d: got 0x%02h, required 0x%02h", k, last_dec[k], 8'(8'h31 + k));
      end
    end
`ifdef PACKET_SENDER_CHECKSUM_EN
    n_vec++;
    if (last_dec[PS] !== 8'hDD) begin
      n_err++;
      $display("FAIL single_checksum: got 0x%02h, required 0xDD", last_dec[PS]);
    end
`endif
  endtask

  task automatic test_enable_ignored();
    run_packet(rand_packet(), 1'b0, 1'b1, 1'b0, 1'b0, '0, "enable_spam");
    check_idle(2 * FRAME, "enable_spam_after");
  endtask

  task automatic test_packet_change();
    packet = pkt_letters;
    run_packet(pkt_digits, 1'b0, 1'b0, 1'b1, 1'b0, '0, "packet_change");
    for (int k = 0; k < PS; k++) begin
      n_vec++;
      if (last_dec[k] !== 8'(8'h31 + k)) begin
        n_err++;
        $display("FAIL packet_change byte %0d: got 0x%02h, required 0x%02h", k, last_dec[k], 8'(8'h31 + k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] p1;
    logic [PW-1:0] p2;
    p1 = rand_packet();
    p2 = rand_packet();
    run_packet(p1, 1'b0, 1'b0, 1'b0, 1'b1, p2, "b2b_first");
    run_packet(p2, 1'b1, 1'b0, 1'b0, 1'b0, '0, "b2b_second");
    check_idle(10, "b2b_after");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      run_packet(rand_packet(), 1'b0, 1'b0, 1'b0, 1'b0, '0, "random");
      check_idle(int'($urandom_range(0, 5)), "random_gap");
    end
  endtask

  initial begin
    pkt_digits  = "123456789";
    pkt_letters = "ABCDEFGHI";
    test_reset();
    test_single();
    test_enable_ignored();
    test_packet_change();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
